// File: rtl/ysyx_22050854_ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to imem, tags them with
// their PC, and buffers in-order responses as {pc, inst} for decode. Redirects flush and drop.
module ysyx_22050854_ifu_fetch #(
  parameter logic [63:0] RESET_PC        = 64'h8000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
);
  // Handshakes: a transfer happens on a rising edge where valid && ready; a valid source
  // holds its payload stable until accepted. imem responses carry no ready (never stalled).
  localparam int TD = (MAX_OUTSTANDING < 2) ? 2 : MAX_OUTSTANDING;
  localparam int TW = $clog2(TD);
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + FIFO_DEPTH + 1);
  localparam logic [CW-1:0] MAX_C   = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   tag_mem [TD];
  logic [TW-1:0] tag_wr, tag_rd;
  logic [CW-1:0] inflight, drop_cnt, fifo_count;
  logic [63:0]   fifo_pc [FIFO_DEPTH];
  logic [31:0]   fifo_inst [FIFO_DEPTH];
  logic [FW-1:0] fifo_wr, fifo_rd;

  logic req_fire, rsp_keep, rsp_drop, pop, rsp_legal;
  logic unused_ok;

  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(TD - 1)) ? '0 : p + TW'(1);
  endfunction

  assign unused_ok = ^redirect_pc[1:0];

  // Credit uses registered counts only, so a response this cycle frees no slot until next cycle.
  always_comb begin
    imem_req_valid = rst && !redirect_valid
                     && ((inflight + drop_cnt) < MAX_C)
                     && ((inflight + fifo_count) < DEPTH_C);
    imem_req_addr  = fetch_pc;
    out_valid      = (fifo_count != '0) && !redirect_valid;
    out_pc         = fifo_pc[fifo_rd];
    out_inst       = fifo_inst[fifo_rd];
    req_fire       = imem_req_valid && imem_req_ready;
    rsp_legal      = (inflight != '0) || (drop_cnt != '0);
    rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
    rsp_keep       = imem_rsp_valid && (drop_cnt == '0) && (inflight != '0);
    pop            = out_valid && out_ready;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      tag_wr     <= '0;
      tag_rd     <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
      for (int i = 0; i < TD; i++) tag_mem[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight becomes a response to swallow.
      fetch_pc   <= {redirect_pc[63:2], 2'b00};
      tag_wr     <= '0;
      tag_rd     <= '0;
      inflight   <= '0;
      fifo_wr    <= '0;
      fifo_rd    <= '0;
      fifo_count <= '0;
      drop_cnt   <= drop_cnt + inflight - CW'(imem_rsp_valid && rsp_legal);
    end else begin
      if (req_fire) begin
        tag_mem[tag_wr] <= fetch_pc;
        tag_wr          <= tag_next(tag_wr);
        fetch_pc        <= fetch_pc + 64'd4;
      end
      if (rsp_keep) begin
        fifo_pc[fifo_wr]   <= tag_mem[tag_rd];
        fifo_inst[fifo_wr] <= imem_rsp_data;
        fifo_wr            <= fifo_wr + FW'(1);
        tag_rd             <= tag_next(tag_rd);
      end
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
      if (pop) fifo_rd <= fifo_rd + FW'(1);
      inflight   <= inflight + CW'(req_fire) - CW'(rsp_keep);
      fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) assert (!(imem_rsp_valid && !rsp_legal));
  end
`endif

endmodule
